// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexes six BCD digits onto one active-low 7-segment bus with anode guard, blink and DPs.
// Optional DISPLAY_LZB_EN blanks a leading zero in the hours-tens slot outside configuration mode.
module display_scan_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLINK_HZ  = 2,
    parameter int GUARD_CYC = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s_unidade,
    input  logic [3:0] s_dezena,
    input  logic [3:0] m_unidade,
    input  logic [3:0] m_dezena,
    input  logic [3:0] h_unidade,
    input  logic [3:0] h_dezena,
    input  logic [2:0] config_digit,
    input  logic       is_config,
    input  logic [1:0] state_out,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);
    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic [2:0]    slot;
    logic          blink_phase;
    logic [3:0]    snap [6];
    logic [3:0]    digit;
    logic          scan_tc, blink_tc, blank, lzb;
    logic [6:0]    seg_n, dec;
    logic          dp_n;
    logic [5:0]    an_n;

    assign scan_tc  = scan_cnt == SW'(SCAN_DIV - 1);
    assign blink_tc = blink_cnt == BW'(BLINK_DIV - 1);
    assign digit    = snap[slot];
    // config_digit above 5 never equals a slot, so nothing blanks
    assign blank    = is_config && blink_phase && slot == config_digit;

`ifdef DISPLAY_LZB_EN
    assign lzb = slot == 3'd5 && digit == 4'd0 && !is_config;
`else
    assign lzb = 1'b0;
`endif

    always_comb begin
        case (digit)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    end

    always_comb begin
        seg_n = blank || lzb ? 7'h7F : dec;
        dp_n  = blank ? 1'b1 : !(slot == 3'd2 || slot == 3'd4 || (slot == 3'd0 && state_out == 2'b01));
        an_n  = scan_cnt < SW'(GUARD_CYC) ? 6'h3F : ~(6'b1 << slot);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt    <= '0;
            blink_cnt   <= '0;
            slot        <= 3'd0;
            blink_phase <= 1'b0;
            snap        <= '{default: 4'd0};
            seg         <= 7'h7F;
            dp          <= 1'b1;
            an          <= 6'h3F;
        end else begin
            seg       <= seg_n;
            dp        <= dp_n;
            an        <= an_n;
            scan_cnt  <= scan_tc ? '0 : scan_cnt + 1'b1;
            blink_cnt <= blink_tc ? '0 : blink_cnt + 1'b1;
            if (blink_tc)
                blink_phase <= ~blink_phase;
            if (scan_tc)
                slot <= slot == 3'd5 ? 3'd0 : slot + 3'd1;
            // frame-wide snapshot prevents tearing while digits update mid-frame
            if (scan_tc && slot == 3'd5)
                snap <= '{s_unidade, s_dezena, m_unidade, m_dezena, h_unidade, h_dezena};
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: checks display_scan_ctrl against a frame-position model plus directed literal points.
module tb_display_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] s_unidade = 4'd6, s_dezena = 4'd5, m_unidade = 4'd4;
    logic [3:0] m_dezena = 4'd3, h_unidade = 4'd2, h_dezena = 4'd1;
    logic [2:0] config_digit = 3'd0;
    logic       is_config = 1'b0;
    logic [1:0] state_out = 2'b00;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    int errors = 0, checks = 0;
    int p = 0;
    logic valid = 1'b0;
    logic [3:0] msnap [6];
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [5:0] exp_an;

    display_scan_ctrl #(.CLK_HZ(1200), .SCAN_HZ(100), .BLINK_HZ(10), .GUARD_CYC(2)) dut (
        .clk(clk), .reset(reset),
        .s_unidade(s_unidade), .s_dezena(s_dezena), .m_unidade(m_unidade),
        .m_dezena(m_dezena), .h_unidade(h_unidade), .h_dezena(h_dezena),
        .config_digit(config_digit), .is_config(is_config), .state_out(state_out),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h3F;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // p counts clock edges since reset release: 12-cycle slots, 72-cycle frames, 60-cycle blink halves
    always @(posedge clk) begin
        automatic int sl = (p / 12) % 6;
        automatic bit ph = ((p / 60) % 2) == 1;
        automatic bit bl = is_config && ph && int'(config_digit) == sl;
        automatic bit lz = 1'b0;
`ifdef DISPLAY_LZB_EN
        lz = sl == 5 && msnap[sl] == 4'd0 && !is_config;
`endif
        valid <= 1'b1;
        if (!reset) begin
            p       <= 0;
            msnap   <= '{default: 4'd0};
            exp_seg <= 7'h7F;
            exp_dp  <= 1'b1;
            exp_an  <= 6'h3F;
        end else begin
            exp_seg <= (bl || lz) ? 7'h7F : dec(msnap[sl]);
            exp_dp  <= bl ? 1'b1 : !(sl == 2 || sl == 4 || (sl == 0 && state_out == 2'b01));
            exp_an  <= (p % 12) < 2 ? 6'h3F : 6'h3F & ~(6'd1 << sl);
            if (p % 72 == 71)
                msnap <= '{s_unidade, s_dezena, m_unidade, m_dezena, h_unidade, h_dezena};
            p <= p + 1;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            check("model_seg", {1'b0, seg}, {1'b0, exp_seg});
            check("model_dp", {7'b0, dp}, {7'b0, exp_dp});
            check("model_an", {2'b0, an}, {2'b0, exp_an});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(4);
        check("reset_seg", {1'b0, seg}, 8'h7F);
        check("reset_dp", {7'b0, dp}, 8'h01);
        check("reset_an", {2'b0, an}, 8'h3F);
        reset = 1'b1;
        step(3);
        check("f0_slot0_an", {2'b0, an}, 8'h3E);
        check("f0_slot0_seg", {1'b0, seg}, 8'h40);
        step(12);
        check("f0_slot1_an", {2'b0, an}, 8'h3D);
        check("f0_slot1_seg", {1'b0, seg}, 8'h40);
        step(60);
        check("f1_slot0_seg6", {1'b0, seg}, 8'h02);
        s_unidade = 4'd7;
        step(1);
        check("snap_holds_old", {1'b0, seg}, 8'h02);
        step(59);
        check("f1_slot5_an", {2'b0, an}, 8'h1F);
        check("f1_slot5_seg1", {1'b0, seg}, 8'h79);
        step(12);
        check("snap_new_value", {1'b0, seg}, 8'h78);
        is_config = 1'b1;
        config_digit = 3'd2;
        step(96);
        check("blink_ph0_seg", {1'b0, seg}, 8'h19);
        check("blink_ph0_dp", {7'b0, dp}, 8'h00);
        step(72);
        check("blink_ph1_seg", {1'b0, seg}, 8'h7F);
        check("blink_ph1_dp", {7'b0, dp}, 8'h01);
        check("blink_ph1_an", {2'b0, an}, 8'h3B);
        config_digit = 3'd6;
        step(144);
        check("cfg6_no_blank", {1'b0, seg}, 8'h19);
        is_config = 1'b0;
        state_out = 2'b01;
        step(48);
        check("chrono_dp0", {7'b0, dp}, 8'h00);
        h_dezena = 4'hB;
        step(132);
        check("dash_seg", {1'b0, seg}, 8'h3F);
        state_out = 2'b11;
        step(12);
        check("mode11_dp0", {7'b0, dp}, 8'h01);
        h_dezena = 4'd0;
        step(132);
`ifdef DISPLAY_LZB_EN
        check("lzb_blank", {1'b0, seg}, 8'h7F);
`else
        check("lzb_off_zero", {1'b0, seg}, 8'h40);
`endif
        is_config = 1'b1;
        step(72);
        check("lzb_cfg_zero", {1'b0, seg}, 8'h40);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_seg", {1'b0, seg}, 8'h7F);
        check("async_rst_dp", {7'b0, dp}, 8'h01);
        check("async_rst_an", {2'b0, an}, 8'h3F);
        step(3);
        #2 reset = 1'b1;
        step(3);
        check("rerst_slot0_an", {2'b0, an}, 8'h3E);
        check("rerst_slot0_seg", {1'b0, seg}, 8'h40);
        step(160);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
